// File: rtl/jesd_rx_sync_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : jesd_rx_sync_if
// Brief  : Per-lane 8b/10b receive bus (decoded octets plus status flags).
// Rev    : 1.0
// ============================================================================
interface jesd_rx_sync_if #(
    parameter int NLANE = 4
);
    logic [NLANE*32-1:0] lane_data;
    logic [NLANE*4-1:0]  lane_charisk;
    logic [NLANE*4-1:0]  lane_disperr;
    logic [NLANE*4-1:0]  lane_notintable;

    modport master (output lane_data, lane_charisk, lane_disperr, lane_notintable);
    modport slave  (input  lane_data, lane_charisk, lane_disperr, lane_notintable);
endinterface
`default_nettype wire

// File: rtl/jesd_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : jesd_rx_sync
// Brief  : JESD204B RX per-lane code-group sync and SYNC~ release/re-assert.
// Rev    : 1.0
// ============================================================================
module jesd_rx_sync #(
    parameter int NLANE      = 4,
    parameter int K_CNT      = 4,
    parameter int ERR_THRESH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    jesd_rx_sync_if.slave       lane,
    input  logic                lmfc_pulse,
    input  logic                err_clr,
    output logic                sync_n,
    output logic [NLANE-1:0]    cgs_done,
    output logic                link_up,
    output logic [NLANE*8-1:0]  err_cnt,
    output logic [15:0]         resync_cnt
);

    localparam logic [1:0] c_CGS_INIT  = 2'd0;
    localparam logic [1:0] c_CGS_CHECK = 2'd1;
    localparam logic [1:0] c_CGS_DATA  = 2'd2;

    // RELEASED is the only state with bit 1 set, so SYNC~ comes straight off a flop
    localparam logic [1:0] c_SYNC_ASSERT   = 2'b00;
    localparam logic [1:0] c_SYNC_WAIT     = 2'b01;
    localparam logic [1:0] c_SYNC_RELEASED = 2'b10;

    localparam logic [3:0] c_K_CNT      = 4'(K_CNT);
    localparam logic [7:0] c_ERR_THRESH = 8'(ERR_THRESH);

    logic [NLANE-1:0] w_lane_done;
    logic [NLANE-1:0] w_lane_init;
    logic [NLANE-1:0] w_lane_data_nxt;

    logic [1:0]  r_sync_st;
    logic [1:0]  w_sync_nxt;
    logic        r_link_up;
    logic [15:0] r_resync;
    logic        w_all_done;
    logic        w_any_init;

    generate
        for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
            logic [31:0] w_octets;
            logic [3:0]  w_k;
            logic [3:0]  w_de;
            logic [3:0]  w_ni;
            logic        w_err;
            logic        w_allk;
            logic [1:0]  r_st;
            logic [1:0]  w_st_nxt;
            logic [3:0]  r_kcnt;
            logic [3:0]  w_kcnt_nxt;
            logic [7:0]  r_win;
            logic [7:0]  w_win_nxt;
            logic [7:0]  r_errc;
            logic        w_done;
            logic        w_init;
            logic        w_data_nxt;

            assign w_octets = lane.lane_data[32*gi +: 32];
            assign w_k      = lane.lane_charisk[4*gi +: 4];
            assign w_de     = lane.lane_disperr[4*gi +: 4];
            assign w_ni     = lane.lane_notintable[4*gi +: 4];
            assign w_err    = |{w_de, w_ni};
            assign w_allk   = (w_k == 4'hF) && (w_octets == 32'hBCBC_BCBC) && !w_err;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_st   <= c_CGS_INIT;
                    r_kcnt <= 4'd0;
                    r_win  <= 8'd0;
                end else begin
                    r_st   <= w_st_nxt;
                    r_kcnt <= w_kcnt_nxt;
                    r_win  <= w_win_nxt;
                end
            end

            always_comb begin
                w_st_nxt   = r_st;
                w_kcnt_nxt = r_kcnt;
                w_win_nxt  = r_win;
                if (!enable) begin
                    w_st_nxt   = c_CGS_INIT;
                    w_kcnt_nxt = 4'd0;
                    w_win_nxt  = 8'd0;
                end else begin
                    case (r_st)
                        c_CGS_INIT: begin
                            if (!w_allk) begin
                                w_kcnt_nxt = 4'd0;
                            end else if (r_kcnt + 4'd1 == c_K_CNT) begin
                                w_st_nxt   = c_CGS_CHECK;
                                w_kcnt_nxt = 4'd0;
                            end else begin
                                w_kcnt_nxt = r_kcnt + 4'd1;
                            end
                        end
                        c_CGS_CHECK: begin
                            w_win_nxt = 8'd0;
                            if (w_err)
                                w_st_nxt = c_CGS_INIT;
                            else if (!w_allk && sync_n)
                                w_st_nxt = c_CGS_DATA;
                        end
                        c_CGS_DATA: begin
                            // an error coinciding with the LMFC clear opens the new window at 1
                            if (lmfc_pulse)
                                w_win_nxt = {7'd0, w_err};
                            else if (w_err)
                                w_win_nxt = r_win + 8'd1;
                            if (w_err && (w_win_nxt == c_ERR_THRESH)) begin
                                w_st_nxt  = c_CGS_INIT;
                                w_win_nxt = 8'd0;
                            end
                        end
                        default: w_st_nxt = c_CGS_INIT;
                    endcase
                end
            end

            always_comb begin
                w_done     = (r_st != c_CGS_INIT);
                w_init     = (r_st == c_CGS_INIT);
                w_data_nxt = (w_st_nxt == c_CGS_DATA);
            end

            assign w_lane_done[gi]     = w_done;
            assign w_lane_init[gi]     = w_init;
            assign w_lane_data_nxt[gi] = w_data_nxt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_errc <= 8'd0;
                else if (err_clr)
                    r_errc <= 8'd0;
                else if (enable && w_err && (r_errc != 8'hFF))
                    r_errc <= r_errc + 8'd1;
            end

            assign err_cnt[8*gi +: 8] = r_errc;
        end
    endgenerate

    assign cgs_done   = w_lane_done;
    assign w_all_done = &w_lane_done;
    assign w_any_init = |w_lane_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_st <= c_SYNC_ASSERT;
            r_link_up <= 1'b0;
            r_resync  <= 16'd0;
        end else begin
            r_sync_st <= w_sync_nxt;
            // once up, link_up holds until SYNC~ itself drops
            r_link_up <= (w_sync_nxt == c_SYNC_RELEASED) && (r_link_up || (&w_lane_data_nxt));
            if ((r_sync_st == c_SYNC_RELEASED) && (w_sync_nxt == c_SYNC_ASSERT) &&
                (r_resync != 16'hFFFF))
                r_resync <= r_resync + 16'd1;
        end
    end

    always_comb begin
        w_sync_nxt = r_sync_st;
        case (r_sync_st)
            c_SYNC_ASSERT: begin
                if (w_all_done && enable)
                    w_sync_nxt = c_SYNC_WAIT;
            end
            c_SYNC_WAIT: begin
                if (w_any_init || !enable)
                    w_sync_nxt = c_SYNC_ASSERT;
                else if (lmfc_pulse && w_all_done)
                    w_sync_nxt = c_SYNC_RELEASED;
            end
            c_SYNC_RELEASED: begin
                if (w_any_init || !enable)
                    w_sync_nxt = c_SYNC_ASSERT;
            end
            default: w_sync_nxt = c_SYNC_ASSERT;
        endcase
    end

    always_comb begin
        sync_n     = r_sync_st[1];
        link_up    = r_link_up;
        resync_cnt = r_resync;
    end

endmodule
`default_nettype wire

// File: tb/tb_jesd_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_jesd_rx_sync
// Brief  : Randomized self-checking bench for jesd_rx_sync against a cycle model.
// Rev    : 1.0
// ============================================================================
module tb_jesd_rx_sync;
    localparam int NLANE      = 4;
    localparam int K_CNT      = 4;
    localparam int ERR_THRESH = 8;
    localparam int LMFC_PER   = 16;

    localparam int ALLK  = 0;
    localparam int DATA  = 1;
    localparam int ERR   = 2;
    localparam int NEARK = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               lmfc_pulse;
    logic               err_clr;
    logic               sync_n;
    logic [NLANE-1:0]   cgs_done;
    logic               link_up;
    logic [NLANE*8-1:0] err_cnt;
    logic [15:0]        resync_cnt;

    jesd_rx_sync_if #(.NLANE(NLANE)) lif();

    jesd_rx_sync #(.NLANE(NLANE), .K_CNT(K_CNT), .ERR_THRESH(ERR_THRESH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lane       (lif),
        .lmfc_pulse (lmfc_pulse),
        .err_clr    (err_clr),
        .sync_n     (sync_n),
        .cgs_done   (cgs_done),
        .link_up    (link_up),
        .err_cnt    (err_cnt),
        .resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: lane phase, K run length, window errors, total errors
    typedef enum int {MI, MC, MD} mlane_t;
    typedef enum int {SL, SW, SH} msync_t;
    mlane_t ml[NLANE];
    int     mk[NLANE];
    int     mw[NLANE];
    int     me[NLANE];
    msync_t ms;
    bit     mlink;
    int     mres;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit lane_err(input int i);
        return (lif.lane_disperr[4*i +: 4] != 4'd0) || (lif.lane_notintable[4*i +: 4] != 4'd0);
    endfunction

    function automatic bit lane_allk(input int i);
        logic [31:0] d;
        logic [3:0]  k;
        d = lif.lane_data[32*i +: 32];
        k = lif.lane_charisk[4*i +: 4];
        if (lane_err(i)) return 1'b0;
        for (int o = 0; o < 4; o++)
            if (!k[o] || d[8*o +: 8] != 8'hBC) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLANE; i++) begin
            ml[i] = MI; mk[i] = 0; mw[i] = 0; me[i] = 0;
        end
        ms = SL; mlink = 1'b0; mres = 0;
    endtask

    task automatic model_step();
        bit     any_init;
        bit     all_data;
        msync_t old_s;
        bit     a;
        bit     e;
        old_s    = ms;
        any_init = 1'b0;
        for (int i = 0; i < NLANE; i++)
            if (ml[i] == MI) any_init = 1'b1;
        for (int i = 0; i < NLANE; i++) begin
            a = lane_allk(i);
            e = lane_err(i);
            if (!enable) begin
                ml[i] = MI; mk[i] = 0; mw[i] = 0;
            end else begin
                case (ml[i])
                    MI: begin
                        if (a) begin
                            mk[i]++;
                            if (mk[i] == K_CNT) begin ml[i] = MC; mk[i] = 0; end
                        end else mk[i] = 0;
                    end
                    MC: begin
                        if (e) ml[i] = MI;
                        else if (!a && old_s == SH) begin ml[i] = MD; mw[i] = 0; end
                    end
                    default: begin
                        if (lmfc_pulse) mw[i] = e ? 1 : 0;
                        else if (e) mw[i]++;
                        if (e && mw[i] >= ERR_THRESH) begin ml[i] = MI; mw[i] = 0; end
                    end
                endcase
            end
            if (err_clr) me[i] = 0;
            else if (enable && e && me[i] < 255) me[i]++;
        end
        case (old_s)
            SL: if (!any_init && enable) ms = SW;
            SW: begin
                if (any_init || !enable) ms = SL;
                else if (lmfc_pulse) ms = SH;
            end
            default: begin
                if (any_init || !enable) begin
                    ms = SL;
                    if (mres < 65535) mres++;
                end
            end
        endcase
        all_data = 1'b1;
        for (int i = 0; i < NLANE; i++)
            if (ml[i] != MD) all_data = 1'b0;
        mlink = (ms == SH) && (mlink || all_data);
    endtask

    task automatic check_outputs();
        logic [NLANE-1:0] exp_done;
        for (int i = 0; i < NLANE; i++) exp_done[i] = (ml[i] != MI);
        chk("sync_n", 64'(sync_n), 64'(ms == SH));
        chk("cgs_done", 64'(cgs_done), 64'(exp_done));
        chk("link_up", 64'(link_up), 64'(mlink));
        chk("resync_cnt", 64'(resync_cnt), 64'(mres));
        for (int i = 0; i < NLANE; i++)
            chk($sformatf("err_cnt[%0d]", i), 64'(err_cnt[8*i +: 8]), 64'(me[i]));
    endtask

    task automatic tick();
        lmfc_pulse = ((cyc % LMFC_PER) == LMFC_PER - 1);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic drive_lane(input int i, input int kind);
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  de;
        logic [3:0]  ni;
        de = 4'd0;
        ni = 4'd0;
        case (kind)
            ALLK:  begin d = 32'hBCBC_BCBC; k = 4'hF; end
            NEARK: begin d = 32'hBCBC_BCBC; k = 4'hE; end
            ERR: begin
                d  = $urandom;
                k  = 4'($urandom_range(0, 15));
                de = 4'($urandom_range(0, 15));
                ni = (de == 4'd0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
            end
            default: begin d = $urandom; k = 4'($urandom_range(0, 15)); end
        endcase
        lif.lane_data[32*i +: 32]     = d;
        lif.lane_charisk[4*i +: 4]    = k;
        lif.lane_disperr[4*i +: 4]    = de;
        lif.lane_notintable[4*i +: 4] = ni;
    endtask

    task automatic drive_all(input int kind);
        for (int i = 0; i < NLANE; i++) drive_lane(i, kind);
    endtask

    task automatic wait_phase(input int p);
        for (int n = 0; n < LMFC_PER && (cyc % LMFC_PER) != p; n++) tick();
    endtask

    task automatic relink(input string tag);
        enable  = 1'b1;
        err_clr = 1'b0;
        for (int n = 0; n < 200 && !mlink; n++) begin
            drive_all(ms == SH ? DATA : ALLK);
            tick();
        end
        chk(tag, 64'(link_up), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int kind[NLANE];
        int left[NLANE];

        // reset
        rst_n = 1'b0; enable = 1'b0; lmfc_pulse = 1'b0; err_clr = 1'b0;
        drive_all(ALLK);
        model_reset();
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;

        // basic link-up
        enable = 1'b1;
        drive_all(ALLK);
        repeat (6) tick();
        chk("basic_cgs_done", 64'(cgs_done), 64'hF);
        for (int n = 0; n < 40 && !mlink; n++) begin
            for (int i = 0; i < NLANE; i++) begin
                lif.lane_data[32*i +: 32]     = 32'h1122_3344;
                lif.lane_charisk[4*i +: 4]    = 4'h0;
                lif.lane_disperr[4*i +: 4]    = 4'h0;
                lif.lane_notintable[4*i +: 4] = 4'h0;
            end
            tick();
        end
        chk("basic_link_up", 64'(link_up), 64'd1);
        chk("basic_err_cnt", 64'(err_cnt), 64'd0);

        // error threshold: 8 errors inside one window on lane 1
        wait_phase(0);
        for (int n = 0; n < 8; n++) begin
            drive_all(DATA); drive_lane(1, ERR); tick();
        end
        drive_all(DATA);
        repeat (2) tick();
        chk("thresh_sync_n", 64'(sync_n), 64'd0);
        chk("thresh_resync", 64'(resync_cnt), 64'd1);
        chk("thresh_err_cnt1", 64'(err_cnt[15:8]), 64'd8);

        // 7 errors only: link stays up
        relink("relink_a");
        wait_phase(0);
        for (int n = 0; n < 7; n++) begin
            drive_all(DATA); drive_lane(1, ERR); tick();
        end
        drive_all(DATA);
        repeat (3) tick();
        chk("seven_err_link_up", 64'(link_up), 64'd1);

        // window clear: 7 errs, pulse+err, 6 errs -> window at 7; one more trips it
        wait_phase(8);
        for (int n = 0; n < 14; n++) begin
            drive_all(DATA); drive_lane(1, ERR); tick();
        end
        chk("win_clear_link_up", 64'(link_up), 64'd1);
        chk("win_clear_resync", 64'(resync_cnt), 64'd1);
        drive_all(DATA); drive_lane(1, ERR); tick();
        drive_all(DATA);
        repeat (2) tick();
        chk("win_eighth_resync", 64'(resync_cnt), 64'd2);

        // randomized bursts
        relink("relink_b");
        for (int i = 0; i < NLANE; i++) left[i] = 0;
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < NLANE; i++) begin
                if (left[i] == 0) begin
                    int r;
                    r       = int'($urandom_range(0, 99));
                    kind[i] = (r < 45) ? ALLK : (r < 80) ? DATA : (r < 90) ? NEARK : ERR;
                    left[i] = int'($urandom_range(1, 12));
                end
                drive_lane(i, kind[i]);
                left[i]--;
            end
            if (!enable) enable = ($urandom_range(0, 9) == 0);
            else         enable = ($urandom_range(0, 199) != 0);
            err_clr = ($urandom_range(0, 49) == 0);
            tick();
        end

        // saturation and clear
        relink("relink_c");
        for (int n = 0; n < 300; n++) begin
            drive_all(DATA); drive_lane(0, ERR); tick();
        end
        chk("sat_err_cnt0", 64'(err_cnt[7:0]), 64'd255);
        err_clr = 1'b1;
        drive_all(DATA); drive_lane(0, ERR); tick();
        err_clr = 1'b0;
        chk("clr_err_cnt0", 64'(err_cnt[7:0]), 64'd0);

        // disable in link-up
        relink("relink_d");
        enable = 1'b0;
        drive_all(DATA);
        tick();
        chk("dis_sync_n", 64'(sync_n), 64'd0);
        chk("dis_cgs_done", 64'(cgs_done), 64'd0);

        // late lane 2: 3 K, data, 4 K
        enable = 1'b1;
        for (int n = 0; n < 8; n++) begin
            drive_all(ALLK);
            drive_lane(2, (n == 3) ? DATA : ALLK);
            tick();
        end
        chk("late_sync_held", 64'(sync_n), 64'd0);
        drive_all(ALLK);
        for (int n = 0; n < 40 && ms != SH; n++) tick();
        chk("late_sync_released", 64'(sync_n), 64'd1);
        relink("relink_e");

        // asynchronous reset between edges
        chk("pre_rst_sync_n", 64'(sync_n), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_rst_sync_n", 64'(sync_n), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive_all(ALLK);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
